prio_arbiter_n: RTL and testbench



---
 rtl/prio_arb_pkg.sv | 21 ++
 rtl/prio_enc_core.sv | 50 +++++
 rtl/prio_arbiter_n.sv | 132 +++++++++++++
 tb/tb_prio_arbiter_n.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// ----------------------------------------------------------------------------
// prio_arb_pkg
// Shared types and helpers for the registered N-input priority arbiter.
//   state_t : arbiter FSM state (IDLE, GRANT)
//   rot_idx : modulo-n index arithmetic, (base + off) mod n, for
//             non-negative operands
// ----------------------------------------------------------------------------
package prio_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Operands are always non-negative here; callers express "minus k" as
    // "plus (n - k)" so the modulo never sees a negative value.
    function automatic int rot_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage : prio_arb_pkg

// File: rtl/prio_enc_core.sv
// ----------------------------------------------------------------------------
// prio_enc_core
// Combinational N-to-W priority encoder with a movable top-priority pointer.
// Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1 (modulo N).
//
// Ports
//   req    in  N  request vector, bit i requests index i
//   ptr    in  W  index holding top priority
//   found  out 1  at least one request is set
//   idx    out W  winning index (meaningful only when found=1)
//   onehot out N  one-hot form of idx, all zeros when found=0
// ----------------------------------------------------------------------------
module prio_enc_core
    import prio_arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    logic [N-1:0] w_rot;
    int           w_sh;
    int           w_hi;

    always_comb begin
        // Rotate right by (ptr+1) mod N, which is the same as rotating left by
        // (N-1-ptr): request ptr lands in bit N-1, so a plain highest-set-bit
        // search walks ptr, ptr-1, ... in the original numbering.
        w_sh  = rot_idx(int'(ptr), 1, N);
        w_rot = N'({req, req} >> w_sh);

        w_hi = 0;
        for (int j = 0; j < N; j++) begin
            if (w_rot[j]) begin
                w_hi = j;
            end
        end

        // Undo the rotation to recover the original request index.
        found  = |req;
        idx    = W'(rot_idx(w_hi, w_sh, N));
        onehot = found ? (N'(1) << idx) : '0;
    end

endmodule : prio_enc_core

// File: rtl/prio_arbiter_n.sv
// ----------------------------------------------------------------------------
// prio_arbiter_n
// Registered N-input priority arbiter with a valid/ready output handshake.
// A sampled request vector is encoded into a grant that is held bit-stable
// until the consumer accepts it; back-to-back grants need no idle cycle.
// The default build is strict fixed priority (bit N-1 highest).
// Defining PRIO_ARB_ROUND_ROBIN_EN adds a rotating priority pointer: after
// each accepted grant the just-served index drops to lowest priority.
//
// Ports
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset
//   req        in  N  level-sensitive request vector
//   out_ready  in  1  consumer accepts the presented grant
//   out_valid  out 1  a grant is presented
//   out_idx    out W  winning index, meaningful while out_valid=1
//   out_onehot out N  one-hot winner, all zeros while out_valid=0
// ----------------------------------------------------------------------------
module prio_arbiter_n
    import prio_arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot
);

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_idx;
    logic [N-1:0] r_onehot;

    logic         w_handshake;
    logic         w_load;
    logic         w_clear;
    logic         w_found;
    logic [W-1:0] w_idx;
    logic [N-1:0] w_onehot;
    logic [W-1:0] w_ptr_eff;

    assign w_handshake = (r_state == GRANT) && out_ready;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_ptr_next;

    // (idx - 1) mod N, written as idx + (N-1) to keep the modulo non-negative;
    // index 0 wraps to N-1.
    assign w_ptr_next = W'(rot_idx(int'(r_idx), N - 1, N));

    // A grant retiring this cycle must already see the rotated pointer so the
    // back-to-back winner skips the index just served.
    assign w_ptr_eff  = w_handshake ? w_ptr_next : r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= W'(N - 1);
        end else if (w_handshake) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    assign w_ptr_eff = W'(N - 1);
`endif

    prio_enc_core #(
        .N (N)
    ) u_enc (
        .req    (req),
        .ptr    (w_ptr_eff),
        .found  (w_found),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_load       = 1'b1;
                    w_state_next = GRANT;
                end
            end
            GRANT: begin
                // Without out_ready the grant is simply held; req is ignored.
                if (out_ready) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_clear      = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_clear      = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_onehot <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_idx    <= w_idx;
                r_onehot <= w_onehot;
            end else if (w_clear) begin
                r_idx    <= '0;
                r_onehot <= '0;
            end
        end
    end

    assign out_valid  = (r_state == GRANT);
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;

endmodule : prio_arbiter_n

// File: tb/tb_prio_arbiter_n.sv
// ----------------------------------------------------------------------------
// tb_prio_arbiter_n
// Scoreboard bench for prio_arbiter_n at N=8, plus short directed sequences
// on N=2 and N=33 instances. Works with or without PRIO_ARB_ROUND_ROBIN_EN.
// ----------------------------------------------------------------------------
module tb_prio_arbiter_n;

    localparam int N = 8;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic        rdy;
    logic        vld;
    logic [2:0]  idx;
    logic [7:0]  oh;

    logic [1:0]  req2;
    logic        rdy2;
    logic        vld2;
    logic        idx2;
    logic [1:0]  oh2;

    logic [32:0] req33;
    logic        rdy33;
    logic        vld33;
    logic [5:0]  idx33;
    logic [32:0] oh33;

    int n_total = 0;
    int n_bad   = 0;
    int sb_q[$];
    int m_ptr;

    prio_arbiter_n #(.N(8)) dut (
        .clk(clk), .rst(rst), .req(req), .out_ready(rdy),
        .out_valid(vld), .out_idx(idx), .out_onehot(oh)
    );

    prio_arbiter_n #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .out_ready(rdy2),
        .out_valid(vld2), .out_idx(idx2), .out_onehot(oh2)
    );

    prio_arbiter_n #(.N(33)) dut33 (
        .clk(clk), .rst(rst), .req(req33), .out_ready(rdy33),
        .out_valid(vld33), .out_idx(idx33), .out_onehot(oh33)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference winner: walk p, p-1, ... modulo N and take the first request.
    function automatic int m_win(input logic [7:0] r, input int p);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (p - k + N) % N;
            if (r[c[2:0]]) return c;
        end
        return 0;
    endfunction

    // Drive one cycle of N=8 stimulus, advance the model, then check after
    // the edge. sb_q holds the grant the DUT should be presenting.
    task automatic step(input logic s_rst, input logic [7:0] s_req, input logic s_rdy);
        rst = s_rst;
        req = s_req;
        rdy = s_rdy;
        if (s_rst) begin
            sb_q.delete();
            m_ptr = N - 1;
        end else begin
            if (sb_q.size() != 0 && s_rdy) begin
                if (RR) m_ptr = (sb_q[0] + N - 1) % N;
                void'(sb_q.pop_front());
            end
            if (sb_q.size() == 0 && s_req != 8'd0) begin
                sb_q.push_back(m_win(s_req, m_ptr));
            end
        end
        @(posedge clk);
        #1;
        chk("valid", 64'(vld), 64'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk("idx", 64'(idx), 64'(sb_q[0]));
            chk("onehot", 64'(oh), 64'(8'd1 << sb_q[0]));
        end else begin
            chk("onehot_idle", 64'(oh), 64'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        rdy   = 1'b0;
        req2  = '0;
        rdy2  = 1'b1;
        req33 = '0;
        rdy33 = 1'b1;
        m_ptr = N - 1;

        // Reset and basic grant
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_v2", 64'(vld2), 64'd0);
        chk("rst_v33", 64'(vld33), 64'd0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'b0010_0100, 1'b0);
        chk("basic_idx5", 64'(idx), 64'd5);

        // Hold under backpressure while req changes and drops
        step(1'b0, 8'h80, 1'b0);
        step(1'b0, 8'h80, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("hold_idx5", 64'(idx), 64'd5);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Back-to-back with all requests present
        for (int i = 0; i < 10; i++) step(1'b0, 8'hFF, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Two contenders at the extremes
        for (int i = 0; i < 5; i++) step(1'b0, 8'h81, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Reset while a grant is outstanding
        step(1'b0, 8'h24, 1'b0);
        step(1'b0, 8'h24, 1'b0);
        step(1'b1, 8'h24, 1'b0);
        chk("rst_mid_idx", 64'(idx), 64'd0);
        step(1'b0, 8'h81, 1'b1);
        chk("post_rst_idx7", 64'(idx), 64'd7);
        step(1'b0, 8'h81, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // N=2: both requests held, ready high
        req2 = 2'b11;
        @(posedge clk); #1;
        chk("n2_v", 64'(vld2), 64'd1);
        chk("n2_idx_a", 64'(idx2), 64'd1);
        chk("n2_oh_a", 64'(oh2), 64'd2);
        @(posedge clk); #1;
        chk("n2_idx_b", 64'(idx2), RR ? 64'd0 : 64'd1);
        chk("n2_ones", 64'($countones(oh2)), 64'd1);
        @(posedge clk); #1;
        chk("n2_idx_wrap", 64'(idx2), 64'd1);
        req2 = 2'b00;
        @(posedge clk); #1;
        chk("n2_v_idle", 64'(vld2), 64'd0);
        chk("n2_oh_idle", 64'(oh2), 64'd0);

        // N=33: extremes contend, then wrap from index 0 back to 32
        req33 = 33'h1_0000_0001;
        @(posedge clk); #1;
        chk("n33_idx_a", 64'(idx33), 64'd32);
        chk("n33_oh_a", 64'(oh33), 64'h1_0000_0000);
        @(posedge clk); #1;
        chk("n33_idx_b", 64'(idx33), RR ? 64'd0 : 64'd32);
        chk("n33_ones", 64'($countones(oh33)), 64'd1);
        @(posedge clk); #1;
        chk("n33_idx_wrap", 64'(idx33), 64'd32);
        req33 = 33'h0_8000_0002;
        @(posedge clk); #1;
        chk("n33_idx_c", 64'(idx33), 64'd31);
        chk("n33_oh_c", 64'(oh33), 64'h0_8000_0000);
        req33 = '0;
        @(posedge clk); #1;
        chk("n33_v_idle", 64'(vld33), 64'd0);
        chk("n33_oh_idle", 64'(oh33), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_prio_arbiter_n
